// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, MIPS opcode/funct values and the issue FSM encoding
// shared by alu_issue_ctrl and its decoder.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_EQ,
    BR_NE
  } br_kind_t;

  // CarryOut from the ALU only means something for the arithmetic ops
  function automatic logic op_has_carry(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational instruction decode to ALU op, operand selection,
// destination, write enable and branch kind. ALU_OVF_EN adds the overflow-check flag.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  op,
  output logic        use_imm,
  output logic        sign_ext,
  output logic [4:0]  dest,
  output logic        wr_en,
  output br_kind_t    br_kind,
`ifdef ALU_OVF_EN
  output logic        ovf_chk,
`endif
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    op       = ALU_AND;
    use_imm  = 1'b1;
    sign_ext = 1'b0;
    dest     = instr[20:16];
    wr_en    = 1'b0;
    br_kind  = BR_NONE;
    illegal  = 1'b0;
`ifdef ALU_OVF_EN
    ovf_chk  = 1'b0;
`endif
    case (opcode)
      OPC_RTYPE: begin
        use_imm = 1'b0;
        dest    = instr[15:11];
        wr_en   = 1'b1;
        case (funct)
          FN_ADD: begin
            op = ALU_ADD;
`ifdef ALU_OVF_EN
            ovf_chk = 1'b1;
`endif
          end
          FN_ADDU: op = ALU_ADD;
          FN_SUB: begin
            op = ALU_SUB;
`ifdef ALU_OVF_EN
            ovf_chk = 1'b1;
`endif
          end
          FN_SUBU: op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          default: begin
            illegal = 1'b1;
            wr_en   = 1'b0;
          end
        endcase
      end
      OPC_ADDI: begin
        op       = ALU_ADD;
        sign_ext = 1'b1;
        wr_en    = 1'b1;
`ifdef ALU_OVF_EN
        ovf_chk  = 1'b1;
`endif
      end
      OPC_SLTI: begin
        op       = ALU_SLT;
        sign_ext = 1'b1;
        wr_en    = 1'b1;
      end
      OPC_ANDI: begin
        op    = ALU_AND;
        wr_en = 1'b1;
      end
      OPC_ORI: begin
        op    = ALU_OR;
        wr_en = 1'b1;
      end
      OPC_LW, OPC_SW: begin
        op       = ALU_ADD;
        sign_ext = 1'b1;
      end
      OPC_BEQ, OPC_BNE: begin
        op      = ALU_SUB;
        use_imm = 1'b0;
        br_kind = (opcode == OPC_BEQ) ? BR_EQ : BR_NE;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction, drives an external combinational ALU and
// returns a registered execute result. Define ALU_OVF_EN to add the Overflow output.
//
// state      | meaning
// ST_IDLE    | InReady=1, waiting for InValid; Op/A/B registered on accept
// ST_ISSUE   | Op/A/B presented to the ALU
// ST_CAPTURE | ALU response sampled into the result registers
// ST_DONE    | OutValid=1, outputs held until OutReady
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  output logic [OP_W-1:0]  Op,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluZero,
  input  logic             AluCarry,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       DestReg,
  output logic             WriteEn,
  output logic             BranchTaken,
  output logic             CarryOut,
`ifdef ALU_OVF_EN
  output logic             Overflow,
`endif
  output logic             Illegal
);

  state_t     state;
  logic [2:0] dec_op;
  logic       dec_use_imm, dec_sign_ext, dec_wr_en, dec_illegal;
  logic [4:0] dec_dest;
  br_kind_t   dec_br_kind;
  logic [WIDTH-1:0] imm_ext;

  logic [4:0] dest_q;
  logic       we_q, ill_q, carry_ok_q;
  br_kind_t   br_q;
  logic       ovf_now;

  alu_issue_decode u_decode (
    .instr    (Instr),
    .op       (dec_op),
    .use_imm  (dec_use_imm),
    .sign_ext (dec_sign_ext),
    .dest     (dec_dest),
    .wr_en    (dec_wr_en),
    .br_kind  (dec_br_kind),
`ifdef ALU_OVF_EN
    .ovf_chk  (dec_ovf_chk),
`endif
    .illegal  (dec_illegal)
  );

  assign imm_ext = dec_sign_ext ? {{(WIDTH-16){Instr[15]}}, Instr[15:0]}
                                : {{(WIDTH-16){1'b0}}, Instr[15:0]};

`ifdef ALU_OVF_EN
  logic dec_ovf_chk, ovf_chk_q, ovf_sub_q;
  // signed overflow judged from the operand and result sign bits only
  assign ovf_now = ovf_chk_q
                 & (ovf_sub_q ? (A[WIDTH-1] != B[WIDTH-1]) : (A[WIDTH-1] == B[WIDTH-1]))
                 & (AluResult[WIDTH-1] != A[WIDTH-1]);
`else
  assign ovf_now = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      InReady     <= 1'b1;
      OutValid    <= 1'b0;
      Op          <= '0;
      A           <= '0;
      B           <= '0;
      Result      <= '0;
      DestReg     <= '0;
      WriteEn     <= 1'b0;
      BranchTaken <= 1'b0;
      CarryOut    <= 1'b0;
      Illegal     <= 1'b0;
      dest_q      <= '0;
      we_q        <= 1'b0;
      ill_q       <= 1'b0;
      carry_ok_q  <= 1'b0;
      br_q        <= BR_NONE;
`ifdef ALU_OVF_EN
      Overflow    <= 1'b0;
      ovf_chk_q   <= 1'b0;
      ovf_sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (InValid) begin
            state      <= ST_ISSUE;
            InReady    <= 1'b0;
            dest_q     <= dec_dest;
            we_q       <= dec_wr_en;
            ill_q      <= dec_illegal;
            br_q       <= dec_br_kind;
            carry_ok_q <= op_has_carry(dec_op);
`ifdef ALU_OVF_EN
            ovf_chk_q  <= dec_ovf_chk;
            ovf_sub_q  <= (dec_op == ALU_SUB);
`endif
            if (dec_illegal) begin
              Op <= '0;
              A  <= '0;
              B  <= '0;
            end else begin
              Op <= OP_W'(dec_op);
              A  <= RsData;
              B  <= dec_use_imm ? imm_ext : RtData;
            end
          end
        end
        ST_ISSUE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          state    <= ST_DONE;
          OutValid <= 1'b1;
          DestReg  <= dest_q;
          Illegal  <= ill_q;
          if (ill_q) begin
            Result      <= '0;
            WriteEn     <= 1'b0;
            BranchTaken <= 1'b0;
            CarryOut    <= 1'b0;
`ifdef ALU_OVF_EN
            Overflow    <= 1'b0;
`endif
          end else begin
            Result      <= AluResult;
            WriteEn     <= we_q & ~ovf_now;
            BranchTaken <= (br_q == BR_EQ) ? AluZero : (br_q == BR_NE) ? ~AluZero : 1'b0;
            CarryOut    <= carry_ok_q & AluCarry;
`ifdef ALU_OVF_EN
            Overflow    <= ovf_now;
`endif
          end
        end
        ST_DONE: begin
          if (OutReady) begin
            state    <= ST_IDLE;
            OutValid <= 1'b0;
            InReady  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random instructions through alu_issue_ctrl with a
// behavioural ALU and a rule-level reference model. Honours ALU_OVF_EN.
module tb_alu_issue_ctrl;

  logic        Clk, Reset_n, InValid, InReady, OutValid, OutReady;
  logic [31:0] Instr, RsData, RtData, A, B, AluResult, Result;
  logic [2:0]  Op;
  logic        AluZero, AluCarry, WriteEn, BranchTaken, CarryOut, Illegal;
  logic [4:0]  DestReg;
`ifdef ALU_OVF_EN
  logic        Overflow;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  alu_issue_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .RsData(RsData), .RtData(RtData), .Op(Op), .A(A), .B(B),
    .AluResult(AluResult), .AluZero(AluZero), .AluCarry(AluCarry),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result), .DestReg(DestReg),
    .WriteEn(WriteEn), .BranchTaken(BranchTaken), .CarryOut(CarryOut),
`ifdef ALU_OVF_EN
    .Overflow(Overflow),
`endif
    .Illegal(Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // external combinational ALU; carry always reports something so forcing is visible
  logic [32:0] alu_sum, alu_dif;
  assign alu_sum = {1'b0, A} + {1'b0, B};
  assign alu_dif = {1'b0, A} + {1'b0, ~B} + 33'd1;
  always_comb begin
    AluResult = 32'd0;
    AluCarry  = alu_sum[32];
    case (Op)
      3'b000: AluResult = A & B;
      3'b001: AluResult = A | B;
      3'b010: AluResult = alu_sum[31:0];
      3'b110: begin AluResult = alu_dif[31:0]; AluCarry = alu_dif[32]; end
      3'b111: AluResult = {31'd0, (A < B)};
      default: AluResult = 32'd0;
    endcase
  end
  assign AluZero = (AluResult == 32'd0);

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic [4:0]  dest;
    logic        we, br, c, ill, ovf;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0]  opc = ins[31:26];
    logic [5:0]  fn  = ins[5:0];
    logic [31:0] se  = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] ze  = {16'd0, ins[15:0]};
    logic        chk_ovf = 1'b0;
    e = '0;
    e.a = rs; e.b = se; e.dest = ins[20:16];
    case (opc)
      6'h00: begin
        e.b = rt; e.dest = ins[15:11]; e.we = 1'b1;
        case (fn)
          6'h20: begin e.op = 3'b010; chk_ovf = 1'b1; end
          6'h21: e.op = 3'b010;
          6'h22: begin e.op = 3'b110; chk_ovf = 1'b1; end
          6'h23: e.op = 3'b110;
          6'h24: e.op = 3'b000;
          6'h25: e.op = 3'b001;
          6'h2A: e.op = 3'b111;
          default: e.ill = 1'b1;
        endcase
      end
      6'h08: begin e.op = 3'b010; e.we = 1'b1; chk_ovf = 1'b1; end
      6'h0A: begin e.op = 3'b111; e.we = 1'b1; end
      6'h0C: begin e.op = 3'b000; e.b = ze; e.we = 1'b1; end
      6'h0D: begin e.op = 3'b001; e.b = ze; e.we = 1'b1; end
      6'h23, 6'h2B: e.op = 3'b010;
      6'h04, 6'h05: begin e.op = 3'b110; e.b = rt; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.op = 3'b000; e.a = 0; e.b = 0; e.res = 0; e.we = 0;
    end else begin
      case (e.op)
        3'b000: e.res = e.a & e.b;
        3'b001: e.res = e.a | e.b;
        3'b010: begin e.res = e.a + e.b; e.c = ((64'(e.a) + 64'(e.b)) > 64'h0_FFFF_FFFF); end
        3'b110: begin e.res = e.a - e.b; e.c = (e.a >= e.b); end
        default: e.res = (e.a < e.b) ? 32'd1 : 32'd0;
      endcase
      if (opc == 6'h04) e.br = (e.res == 0);
      if (opc == 6'h05) e.br = (e.res != 0);
      if (chk_ovf) begin
        if (e.op == 3'b010)
          e.ovf = ($signed(e.a) >= 0) == ($signed(e.b) >= 0) && ($signed(e.res) >= 0) != ($signed(e.a) >= 0);
        else
          e.ovf = ($signed(e.a) >= 0) != ($signed(e.b) >= 0) && ($signed(e.res) >= 0) != ($signed(e.a) >= 0);
      end
`ifdef ALU_OVF_EN
      if (e.ovf) e.we = 1'b0;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready", InReady, 1);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_op", Op, 0);
    chk("rst_a", A, 0);
    chk("rst_b", B, 0);
    chk("rst_result", Result, 0);
    chk("rst_dest", DestReg, 0);
    chk("rst_we", WriteEn, 0);
    chk("rst_br", BranchTaken, 0);
    chk("rst_carry", CarryOut, 0);
    chk("rst_illegal", Illegal, 0);
`ifdef ALU_OVF_EN
    chk("rst_overflow", Overflow, 0);
`endif
  endtask

  task automatic chk_done(input exp_t e);
    chk("done_out_valid", OutValid, 1);
    chk("done_in_ready", InReady, 0);
    chk("done_op", Op, e.op);
    chk("done_a", A, e.a);
    chk("done_b", B, e.b);
    chk("result", Result, e.res);
    if (!e.ill) chk("dest", DestReg, e.dest);
    chk("write_en", WriteEn, e.we);
    chk("branch", BranchTaken, e.br);
    chk("carry", CarryOut, e.c);
    chk("illegal", Illegal, e.ill);
`ifdef ALU_OVF_EN
    chk("overflow", Overflow, e.ovf);
`endif
  endtask

  task automatic run_txn(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input int hold, input logic noise);
    exp_t e = model(ins, rs, rt);
    @(negedge Clk);
    OutReady = (hold == 0);
    Instr = ins; RsData = rs; RtData = rt; InValid = 1'b1;
    #1 chk("idle_in_ready", InReady, 1);
    @(posedge Clk); #1;
    if (noise) begin
      Instr = $urandom; RsData = $urandom; RtData = $urandom;
    end else InValid = 1'b0;
    @(negedge Clk);
    chk("issue_op", Op, e.op);
    chk("issue_a", A, e.a);
    chk("issue_b", B, e.b);
    chk("issue_out_valid", OutValid, 0);
    chk("issue_in_ready", InReady, 0);
    @(negedge Clk);
    chk("capture_out_valid", OutValid, 0);
    @(negedge Clk);
    chk_done(e);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk_done(e);
    end
    OutReady = 1'b1;
    InValid  = 1'b0;
    @(negedge Clk);
    chk("ret_out_valid", OutValid, 0);
    chk("ret_in_ready", InReady, 1);
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  logic [5:0] opc_tab [12] = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                               6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h1A};
  logic [5:0] fn_tab  [9]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                               6'h2A, 6'h00, 6'h27};

  initial begin
    Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Instr = '0; RsData = '0; RtData = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_reset_state();
    Reset_n = 1'b1;

    run_txn(mk_r(5'd1, 5'd2, 5'd3, 6'h24), 32'ha5a5a5a5, 32'h5a5a5a5a, 0, 1'b0);
    run_txn(mk_r(5'd4, 5'd5, 5'd6, 6'h20), 32'hffffffff, 32'h00000001, 0, 1'b0);
    run_txn(mk_r(5'd4, 5'd5, 5'd7, 6'h20), 32'h7fffffff, 32'h00000001, 0, 1'b0);
    run_txn(mk_i(6'h04, 5'd1, 5'd2, 16'h0010), 32'ha5a5a5a5, 32'ha5a5a5a5, 0, 1'b0);
    run_txn(mk_i(6'h05, 5'd1, 5'd2, 16'h0010), 32'ha5a5a5a5, 32'ha5a5a5a5, 0, 1'b0);
    run_txn(mk_i(6'h08, 5'd1, 5'd9, 16'hfffe), 32'd5, 32'd0, 0, 1'b0);
    run_txn(mk_i(6'h0D, 5'd1, 5'd9, 16'hfffe), 32'd5, 32'd0, 0, 1'b0);
    run_txn(mk_r(5'd8, 5'd9, 5'd10, 6'h2A), 32'h80000000, 32'h00000001, 0, 1'b0);
    run_txn(mk_i(6'h0A, 5'd8, 5'd11, 16'h8000), 32'h00000001, 32'd0, 0, 1'b0);
    // backpressure with the sender hammering InValid the whole time
    run_txn(mk_r(5'd2, 5'd3, 5'd12, 6'h22), 32'd10, 32'd3, 5, 1'b1);
    run_txn(mk_i(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h11111111, 32'h22222222, 0, 1'b0);
    run_txn(mk_r(5'd1, 5'd2, 5'd3, 6'h00), 32'h11111111, 32'h22222222, 1, 1'b0);

    // reset asserted while in CAPTURE
    @(negedge Clk);
    OutReady = 1'b1;
    Instr = mk_r(5'd1, 5'd2, 5'd3, 6'h25); RsData = 32'h0f0f0000; RtData = 32'h000000f0;
    InValid = 1'b1;
    @(posedge Clk); #1 InValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1 chk_reset_state();
    @(posedge Clk); #2 Reset_n = 1'b1;
    run_txn(mk_i(6'h23, 5'd1, 5'd2, 16'h8004), 32'h00001000, 32'd0, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] ins, rs, rt;
      logic [5:0]  opc = opc_tab[$urandom_range(0, 11)];
      if (opc == 6'h00)
        ins = mk_r(5'($urandom), 5'($urandom), 5'($urandom), fn_tab[$urandom_range(0, 8)]);
      else
        ins = mk_i(opc, 5'($urandom), 5'($urandom), 16'($urandom));
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      run_txn(ins, rs, rt, $urandom_range(0, 2), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d assertions", n_assert);
    $fatal(1, "watchdog expired");
  end

endmodule
